// File: rtl/spike_aer_encoder.sv
// Spike AER encoder: captures one timestep of neuron spikes and serialises
// every set bit as an address-event beat, lowest index first, tagged with a
// wrapping timestep counter. A timestep with no spikes produces a single
// "empty" marker beat so the sink still sees every timestep.
module spike_aer_encoder #(
   parameter int NUM_NEURONS = 32,
   parameter int IDX_WIDTH   = 5,
   parameter int TS_WIDTH    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_NEURONS-1:0] spikes_in,
   input  logic                   step_valid,
   output logic                   step_ready,
   output logic                   aer_valid,
   input  logic                   aer_ready,
   output logic [IDX_WIDTH-1:0]   aer_index,
   output logic [TS_WIDTH-1:0]    aer_timestep,
   output logic                   aer_empty,
   output logic                   aer_last,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      MARK = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_NEURONS-1:0] pending_q, pending_d;
   logic [TS_WIDTH-1:0]    tsCount_q, tsCount_d;
   logic [TS_WIDTH-1:0]    beatTs_q, beatTs_d;
   logic                   valid_q, valid_d;
   logic                   started_q;

   logic [NUM_NEURONS-1:0] pendingClr;
   logic [IDX_WIDTH-1:0]   lowIdx;
   logic                   onlyOne;

   // Clearing the lowest set bit removes exactly the event currently presented,
   // and an empty result means that event is the last one of the timestep.
   assign pendingClr = pending_q & (pending_q - NUM_NEURONS'(1));
   assign onlyOne    = (pending_q != '0) && (pendingClr == '0);

   // Priority encoder: the highest loop iteration wins, so scanning downward
   // leaves the lowest set index as the result.
   always_comb begin
      lowIdx = '0;
      for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            lowIdx = IDX_WIDTH'(i);
         end
      end
   end

   // Next-state logic: accept a timestep in IDLE, walk the pending vector in
   // SEND one beat per handshake, or emit the single empty marker in MARK.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      tsCount_d = tsCount_q;
      beatTs_d  = beatTs_q;
      case (state_q)
         IDLE: begin
            if (step_valid && step_ready) begin
               pending_d = spikes_in;
               beatTs_d  = tsCount_q;
               tsCount_d = tsCount_q + TS_WIDTH'(1);
               state_d   = (spikes_in != '0) ? SEND : MARK;
            end
         end
         SEND: begin
            if (aer_ready) begin
               pending_d = pendingClr;
               if (onlyOne) begin
                  state_d = IDLE;
               end
            end
         end
         MARK: begin
            if (aer_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
      valid_d = (state_d != IDLE);
   end

   // State register; reset throws away any events still pending so nothing of
   // an aborted timestep leaks out afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         tsCount_q <= '0;
         beatTs_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         tsCount_q <= tsCount_d;
         beatTs_q  <= beatTs_d;
         valid_q   <= valid_d;
      end
   end

   // Holds step_ready low while in reset and until the first clock edge after
   // release, so the upstream never sees ready during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         started_q <= 1'b0;
      end else begin
         started_q <= 1'b1;
      end
   end

   assign step_ready   = (state_q == IDLE) && started_q;
   assign busy         = (state_q != IDLE);
   assign aer_valid    = valid_q;
   assign aer_index    = (state_q == SEND) ? lowIdx : '0;
   assign aer_timestep = beatTs_q;
   assign aer_empty    = (state_q == MARK);
   assign aer_last     = (state_q == MARK) || ((state_q == SEND) && onlyOne);

endmodule
